// File: rtl/vx_axi_write_responder.sv
// ----------------------------------------------------------------------------
// vx_axi_write_responder
//
// AXI4 write-channel slave. Accepts one AW burst at a time, turns each W beat
// into a single-beat word-addressed memory write request, and returns a B
// response tagged with the captured AWID once the last beat has been taken
// by the memory port.
//
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous, active-low
//   s_axi_aw*                AW channel (valid/ready/addr/id/len/size/burst)
//   s_axi_w*                 W channel (valid/ready/data/strb/last)
//   s_axi_b*                 B channel (valid/ready/id/resp)
//   mem_req_*                posted memory write request (valid/ready/addr/
//                            data/byteen); addr is the word address
// ----------------------------------------------------------------------------
module vx_axi_write_responder #(
   parameter int AXI_DATA_WIDTH = 512,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_TID_WIDTH  = 8,
   localparam int BYTES          = AXI_DATA_WIDTH / 8,
   localparam int LOG2_BYTES     = $clog2(BYTES),
   localparam int MEM_ADDR_WIDTH = AXI_ADDR_WIDTH - LOG2_BYTES
) (
   input  logic                      clk,
   input  logic                      reset,

   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [AXI_TID_WIDTH-1:0]  s_axi_awid,
   input  logic [7:0]                s_axi_awlen,
   input  logic [2:0]                s_axi_awsize,
   input  logic [1:0]                s_axi_awburst,

   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
   input  logic [BYTES-1:0]          s_axi_wstrb,
   input  logic                      s_axi_wlast,

   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   output logic [AXI_TID_WIDTH-1:0]  s_axi_bid,
   output logic [1:0]                s_axi_bresp,

   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
   output logic [AXI_DATA_WIDTH-1:0] mem_req_data,
   output logic [BYTES-1:0]          mem_req_byteen
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                    r_state;
   logic [AXI_ADDR_WIDTH-1:0] r_addr;
   logic [AXI_TID_WIDTH-1:0]  r_id;
   logic [7:0]                r_len;
   logic [2:0]                r_size;
   logic [1:0]                r_burst;
   logic [7:0]                r_cnt;
   // r_drain: burst rejected at AW time, beats are swallowed.
   // r_err:   any error for this burst (drain or wlast mismatch).
   // A wlast mismatch alone does not switch to draining, so the remaining
   // beats of that burst are still written.
   logic                      r_drain;
   logic                      r_err;

   logic                      w_in_data;
   logic                      w_beat;
   logic                      w_last;
   logic                      w_aw_err;
   logic [AXI_ADDR_WIDTH-1:0] w_addr_step;

   assign w_in_data   = (r_state == S_DATA);
   assign w_beat      = w_in_data && s_axi_wvalid && s_axi_wready;
   assign w_last      = (r_cnt == r_len);
   // awburst[1] covers both WRAP (2) and the reserved encoding (3).
   assign w_aw_err    = s_axi_awburst[1] || (int'(s_axi_awsize) > LOG2_BYTES);
   assign w_addr_step = {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1} << r_size;

   assign s_axi_awready  = (r_state == S_IDLE);
   // W ready and mem valid are zero-latency pass-throughs while writing.
   assign s_axi_wready   = w_in_data && (r_drain || mem_req_ready);
   assign mem_req_valid  = w_in_data && !r_drain && s_axi_wvalid;
   assign mem_req_addr   = r_addr[AXI_ADDR_WIDTH-1:LOG2_BYTES];
   assign mem_req_data   = s_axi_wdata;
   assign mem_req_byteen = s_axi_wstrb;

   assign s_axi_bvalid   = (r_state == S_RESP);
   assign s_axi_bid      = r_id;
   assign s_axi_bresp    = (r_state == S_RESP && r_err) ? 2'b10 : 2'b00;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_id    <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_cnt   <= '0;
         r_drain <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (s_axi_awvalid) begin
                  r_addr  <= s_axi_awaddr;
                  r_id    <= s_axi_awid;
                  r_len   <= s_axi_awlen;
                  r_size  <= s_axi_awsize;
                  r_burst <= s_axi_awburst;
                  r_cnt   <= '0;
                  r_drain <= w_aw_err;
                  r_err   <= w_aw_err;
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_beat) begin
                  r_cnt <= r_cnt + 8'd1;
                  if (r_burst == 2'b01) begin
                     r_addr <= r_addr + w_addr_step;
                  end
                  if (s_axi_wlast != w_last) begin
                     r_err <= 1'b1;
                  end
                  // The count, not wlast, decides where the burst ends.
                  if (w_last) begin
                     r_state <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               if (s_axi_bready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
